// File: rtl/bcd_serial_adder_ctrl.sv
// Serial packed-BCD adder: one digit per clock, LSD first, start/busy/done handshake.
// Optional macro BCD_SUB_EN adds a 'sub' port (ten's-complement a-b).
module bcd_serial_adder_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
`ifdef BCD_SUB_EN
  input  logic                sub,
`endif
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [W-1:0]   a_q, b_q, acc;
  logic [CW-1:0]  cnt;
  logic           carry;

  logic [W-1:0]   b_in;
  logic           cin_in;
  logic           inv_in;

  // Subtraction is folded in at latch time so the digit step is always a plain add.
  always_comb begin
    b_in   = b;
    cin_in = cin;
`ifdef BCD_SUB_EN
    if (sub) begin
      cin_in = 1'b1;
      for (int i = 0; i < DIGITS; i++)
        b_in[4*i +: 4] = 4'd9 - b[4*i +: 4];
    end
`endif
    inv_in = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9)
        inv_in = 1'b1;
  end

  logic [3:0]   a_d, b_d, d;
  logic [4:0]   t, t6;
  logic         c_nxt;
  logic [W-1:0] acc_nxt;

  always_comb begin
    a_d = a_q[int'(cnt)*4 +: 4];
    b_d = b_q[int'(cnt)*4 +: 4];
    t   = {1'b0, a_d} + {1'b0, b_d} + {4'b0, carry};
    t6  = t + 5'd6;
    if (t > 5'd9) begin
      d     = t6[3:0];
      c_nxt = 1'b1;
    end else begin
      d     = t[3:0];
      c_nxt = 1'b0;
    end
    acc_nxt = acc;
    acc_nxt[int'(cnt)*4 +: 4] = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b_in;
            carry   <= cin_in;
            invalid <= inv_in;
            cnt     <= '0;
            acc     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          carry <= c_nxt;
          acc   <= acc_nxt;
          if (cnt == CW'(DIGITS - 1)) begin
            sum   <= acc_nxt;
            cout  <= c_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed + randomized bench for bcd_serial_adder_ctrl against a decimal-arithmetic model.
module tb_bcd_serial_adder_ctrl;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst, start, cin, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout, invalid;
  logic [W-1:0] sum;

  int tests = 0;
  int fails = 0;

  bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef BCD_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Valid operands: plain decimal integer arithmetic. Invalid digits: digit rule.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                input logic ci, input logic s,
                                output logic [W-1:0] sm, output logic co, output logic inv);
    int ai, bi, tot, p10, c, t, bd;
    inv = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) inv = 1'b1;
    sm = '0;
    p10 = 1;
    for (int i = 0; i < DIGITS; i++) p10 = p10 * 10;
    if (!inv) begin
      ai = 0; bi = 0;
      for (int i = DIGITS-1; i >= 0; i--) begin
        ai = ai * 10 + int'(av[4*i +: 4]);
        bi = bi * 10 + int'(bv[4*i +: 4]);
      end
      tot = s ? ai + (p10 - 1 - bi) + 1 : ai + bi + int'(ci);
      co  = (tot >= p10);
      tot = tot % p10;
      for (int i = 0; i < DIGITS; i++) begin
        sm[4*i +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end else begin
      c = s ? 1 : int'(ci);
      for (int i = 0; i < DIGITS; i++) begin
        bd = int'(bv[4*i +: 4]);
        if (s) bd = (9 - bd) & 15;
        t = int'(av[4*i +: 4]) + bd + c;
        if (t > 9) begin sm[4*i +: 4] = 4'((t + 6) % 16); c = 1; end
        else       begin sm[4*i +: 4] = 4'(t);            c = 0; end
      end
      co = c[0];
    end
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic s, input string tag);
    logic [W-1:0] es;
    logic         ec, ei;
    int           n;
    model(av, bv, ci, s, es, ec, ei);
    @(negedge clk);
    a = av; b = bv; cin = ci; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check({tag, "_busy_cycles"}, 32'(n), 32'(DIGITS));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_invalid"}, 32'(invalid), 32'(ei));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n, ndone;
    logic [W-1:0] ra, rb;
    logic rc, rs;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_invalid", 32'(invalid), 32'd0);
    rst = 1'b0;

    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, "add");
    check("add_lit_sum", 32'(sum), 32'h6912);
    run_op(16'h9999, 16'h0001, 1'b0, 1'b0, "chain");
    check("chain_lit_sum", 32'(sum), 32'h0000);
    check("chain_lit_cout", 32'(cout), 32'd1);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, "cin");
    check("cin_lit_sum", 32'(sum), 32'h0001);
    run_op(16'h000A, 16'h0000, 1'b0, 1'b0, "inv");
    check("inv_lit_sum", 32'(sum), 32'h0010);
    check("inv_lit_invalid", 32'(invalid), 32'd1);

    // start pulsed during RUN must be ignored
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 16'h5555; b = 16'h4444; start = 1'b1;
    @(negedge clk); start = 1'b0; a = '0; b = '0;
    wait_done(n);
    check("ign_busy_cycles", 32'(n), 32'd2);
    check("ign_done", 32'(done), 32'd1);
    check("ign_sum", 32'(sum), 32'h3333);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ign_extra_done", 32'(ndone), 32'd0);

    // start held high through DONE: back-to-back
    a = 16'h4321; b = 16'h1111; start = 1'b1;
    @(negedge clk);
    wait_done(n);
    check("b2b_first_done", 32'(done), 32'd1);
    check("b2b_first_sum", 32'(sum), 32'h5432);
    a = 16'h0999; b = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    check("b2b_rerun_busy", 32'(busy), 32'd1);
    check("b2b_rerun_done", 32'(done), 32'd0);
    wait_done(n);
    check("b2b_second_cycles", 32'(n), 32'd4);
    check("b2b_second_done", 32'(done), 32'd1);
    check("b2b_second_sum", 32'(sum), 32'h1000);

    // reset on the second RUN cycle
    @(negedge clk);
    a = 16'h123A; b = 16'h0005; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_invalid", 32'(invalid), 32'd0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("mid_rst_quiet", 32'(ndone), 32'd0);

`ifdef BCD_SUB_EN
    run_op(16'h5000, 16'h1234, 1'b0, 1'b1, "sub_pos");
    check("sub_pos_lit_sum", 32'(sum), 32'h3766);
    check("sub_pos_lit_cout", 32'(cout), 32'd1);
    run_op(16'h1234, 16'h5000, 1'b0, 1'b1, "sub_neg");
    check("sub_neg_lit_sum", 32'(sum), 32'h6234);
    check("sub_neg_lit_cout", 32'(cout), 32'd0);
`endif

    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < DIGITS; i++) begin
        ra[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
        rb[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      end
      rc = 1'($urandom_range(0, 1));
`ifdef BCD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rc, rs, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
